// File: rtl/stream_mux_pkg.sv
// rtl/stream_mux_pkg.sv - shared mode encodings and helpers for the round-robin stream mux
//
// Purpose: single home for the arbitration mode encoding so the top level and
// the arbiter agree on it, plus the pointer wrap helper used by both.
// Ports: none (package).

package stream_mux_pkg;

    typedef enum logic [1:0] {
        MODE_FIXED = 2'b00,
        MODE_RR    = 2'b01,
        MODE_FORCE = 2'b10,
        MODE_RSVD  = 2'b11
    } mode_e;

    // Next round-robin position after idx, wrapping at n.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational grant selection for the stream mux
//
// Purpose: picks at most one requesting channel according to the arbitration
// mode. Purely combinational; the pointer is owned by the top level.
// Ports:
//   req      [NCH]  per-channel request (in_valid)
//   ptr      [SW]   round-robin search start
//   mode     [2]    arbitration mode (mode_e encoding)
//   sel      [SW]   forced-select channel index
//   gnt      [NCH]  one-hot grant, zero when nothing is granted
//   gnt_idx  [SW]   index of the granted channel (0 when no grant)

module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter int  NCH = 3,
    localparam int SW  = $clog2(NCH)
) (
    input  logic [NCH-1:0] req,
    input  logic [SW-1:0]  ptr,
    input  logic [1:0]     mode,
    input  logic [SW-1:0]  sel,
    output logic [NCH-1:0] gnt,
    output logic [SW-1:0]  gnt_idx
);

    mode_e mode_w;
    int    start;
    int    force_idx;
    int    k;
    logic  found;

    assign mode_w = mode_e'(mode);

    always_comb begin
        gnt       = '0;
        gnt_idx   = '0;
        found     = 1'b0;
        k         = 0;
        // Fixed priority is a round-robin scan that always starts at channel 0;
        // MODE_RR and the reserved encoding both scan from the pointer.
        start     = (mode_w == MODE_FIXED) ? 0 : (int'(ptr) % NCH);
        // Out-of-range select indices clamp to the highest channel.
        force_idx = (int'(sel) >= NCH) ? NCH - 1 : int'(sel);

        if (mode_w == MODE_FORCE) begin
            if (req[force_idx]) begin
                gnt[force_idx] = 1'b1;
                gnt_idx        = SW'(force_idx);
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                k = (start + i) % NCH;
                if (!found && req[k]) begin
                    found   = 1'b1;
                    gnt[k]  = 1'b1;
                    gnt_idx = SW'(k);
                end
            end
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// rtl/stream_mux_rr.sv - N-to-1 stream multiplexer with selectable arbitration
//
// Purpose: merges NCH valid/ready input streams into one registered output
// stream. One beat register; a new beat may load on the same edge the held
// beat leaves, so full throughput is sustained.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid  [NCH]     per-channel valid
//   in_data   [NCH*W]   channel k at [k*W +: W]
//   in_ready  [NCH]     per-channel accept, one-hot or zero
//   mode      [2]       00 fixed, 01 round-robin, 10 forced select, 11 = 01
//   sel       [SW]      forced-select channel
//   out_valid           output register holds a beat
//   out_data  [W]       registered beat
//   out_ready           downstream accept
//   out_ch    [SW]      source channel of out_data

module stream_mux_rr
    import stream_mux_pkg::*;
#(
    parameter int  NCH = 3,
    parameter int  W   = 8,
    localparam int SW  = $clog2(NCH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NCH-1:0]   in_valid,
    input  logic [NCH*W-1:0] in_data,
    output logic [NCH-1:0]   in_ready,
    input  logic [1:0]       mode,
    input  logic [SW-1:0]    sel,
    output logic             out_valid,
    output logic [W-1:0]     out_data,
    input  logic             out_ready,
    output logic [SW-1:0]    out_ch
);

    logic           out_valid_q, out_valid_d;
    logic [W-1:0]   out_data_q,  out_data_d;
    logic [SW-1:0]  out_ch_q,    out_ch_d;
    logic [SW-1:0]  rr_ptr_q,    rr_ptr_d;

    logic [NCH-1:0] gnt;
    logic [SW-1:0]  gnt_idx;
    logic           stage_free;
    logic           accept;

    rr_arbiter #(
        .NCH (NCH)
    ) u_arb (
        .req     (in_valid),
        .ptr     (rr_ptr_q),
        .mode    (mode),
        .sel     (sel),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    // The register can take a beat if it is empty or its beat leaves this edge.
    assign stage_free = !out_valid_q || out_ready;

    // rst_n gates in_ready so nothing appears accepted while reset is held.
    assign in_ready = (rst_n && stage_free) ? gnt : '0;
    assign accept   = rst_n && stage_free && (|gnt);

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        rr_ptr_d    = rr_ptr_q;

        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = in_data[int'(gnt_idx) * W +: W];
            out_ch_d    = gnt_idx;
            rr_ptr_d    = SW'(wrap_inc(int'(gnt_idx), NCH));
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            rr_ptr_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// tb/tb_stream_mux_rr.sv - directed table-driven bench for stream_mux_rr

module tb_stream_mux_rr;

    localparam int NCH = 3;
    localparam int W   = 8;
    localparam int SW  = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NCH-1:0]   in_valid;
    logic [NCH*W-1:0] in_data;
    logic [NCH-1:0]   in_ready;
    logic [1:0]       mode;
    logic [SW-1:0]    sel;
    logic             out_valid;
    logic [W-1:0]     out_data;
    logic             out_ready;
    logic [SW-1:0]    out_ch;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stream_mux_rr #(
        .NCH (NCH),
        .W   (W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mode      (mode),
        .sel       (sel),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .out_ch    (out_ch)
    );

    typedef struct {
        logic [1:0]  mode;
        logic [1:0]  sel;
        logic [2:0]  vld;
        logic [23:0] data;
        logic        ordy;
        logic [2:0]  exp_rdy;
        logic        exp_ov;
        logic [7:0]  exp_d;
        logic [1:0]  exp_ch;
    } vec_t;

    vec_t tbl[16];

    localparam logic [23:0] D0 = 24'hC2B1A0;
    localparam logic [23:0] D1 = 24'hA5B1A0;

    function automatic vec_t mk(input logic [1:0] m, input logic [1:0] s, input logic [2:0] v,
                                input logic [23:0] d, input logic r, input logic [2:0] er,
                                input logic eov, input logic [7:0] ed, input logic [1:0] ec);
        vec_t t;
        t.mode = m; t.sel = s; t.vld = v; t.data = d; t.ordy = r;
        t.exp_rdy = er; t.exp_ov = eov; t.exp_d = ed; t.exp_ch = ec;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] m, input logic [1:0] s, input logic [2:0] v,
                         input logic [23:0] d, input logic r);
        mode = m; sel = s; in_valid = v; in_data = d; out_ready = r;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Each row: state carried from the previous row; rr pointer noted in comments.
        tbl[0]  = mk(2'b01, 2'd0, 3'b111, D0, 1'b1, 3'b001, 1'b1, 8'hA0, 2'd0); // ptr->1
        tbl[1]  = mk(2'b01, 2'd0, 3'b111, D0, 1'b1, 3'b010, 1'b1, 8'hB1, 2'd1); // ptr->2
        tbl[2]  = mk(2'b01, 2'd0, 3'b111, D0, 1'b1, 3'b100, 1'b1, 8'hC2, 2'd2); // ptr->0
        tbl[3]  = mk(2'b01, 2'd0, 3'b111, D0, 1'b1, 3'b001, 1'b1, 8'hA0, 2'd0);
        tbl[4]  = mk(2'b01, 2'd0, 3'b111, D0, 1'b1, 3'b010, 1'b1, 8'hB1, 2'd1);
        tbl[5]  = mk(2'b01, 2'd0, 3'b111, D0, 1'b1, 3'b100, 1'b1, 8'hC2, 2'd2);
        tbl[6]  = mk(2'b00, 2'd0, 3'b110, D0, 1'b1, 3'b010, 1'b1, 8'hB1, 2'd1);
        tbl[7]  = mk(2'b00, 2'd0, 3'b110, D0, 1'b1, 3'b010, 1'b1, 8'hB1, 2'd1);
        tbl[8]  = mk(2'b00, 2'd0, 3'b100, D0, 1'b1, 3'b100, 1'b1, 8'hC2, 2'd2); // ptr->0
        tbl[9]  = mk(2'b10, 2'd3, 3'b111, D1, 1'b1, 3'b100, 1'b1, 8'hA5, 2'd2); // sel clamps
        tbl[10] = mk(2'b10, 2'd1, 3'b101, D1, 1'b1, 3'b000, 1'b0, 8'h00, 2'd0); // drains
        tbl[11] = mk(2'b11, 2'd0, 3'b111, D0, 1'b1, 3'b001, 1'b1, 8'hA0, 2'd0); // ptr->1
        tbl[12] = mk(2'b01, 2'd0, 3'b000, D0, 1'b1, 3'b000, 1'b0, 8'h00, 2'd0);
        tbl[13] = mk(2'b01, 2'd0, 3'b000, D0, 1'b1, 3'b000, 1'b0, 8'h00, 2'd0);
        tbl[14] = mk(2'b01, 2'd0, 3'b111, D0, 1'b1, 3'b010, 1'b1, 8'hB1, 2'd1); // resumes, ptr->2
        tbl[15] = mk(2'b00, 2'd0, 3'b001, D0, 1'b0, 3'b000, 1'b1, 8'hB1, 2'd1); // held

        rst_n = 1'b0;
        drive(2'b01, 2'd0, 3'b111, D0, 1'b1);
        tick();
        tick();
        chk("reset.out_valid", 32'(out_valid), 32'd0);
        chk("reset.out_data",  32'(out_data),  32'd0);
        chk("reset.out_ch",    32'(out_ch),    32'd0);
        chk("reset.in_ready",  32'(in_ready),  32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].mode, tbl[i].sel, tbl[i].vld, tbl[i].data, tbl[i].ordy);
            #1;
            chk($sformatf("v%0d.in_ready", i), 32'(in_ready), 32'(tbl[i].exp_rdy));
            tick();
            chk($sformatf("v%0d.out_valid", i), 32'(out_valid), 32'(tbl[i].exp_ov));
            if (tbl[i].exp_ov) begin
                chk($sformatf("v%0d.out_data", i), 32'(out_data), 32'(tbl[i].exp_d));
                chk($sformatf("v%0d.out_ch", i),   32'(out_ch),   32'(tbl[i].exp_ch));
            end
        end

        // Backpressure: B1/ch1 held, rr pointer at 2.
        for (int c = 0; c < 4; c++) begin
            drive(2'b01, 2'd0, 3'b111, D0, 1'b0);
            #1;
            chk($sformatf("bp%0d.in_ready", c), 32'(in_ready), 32'd0);
            tick();
            chk($sformatf("bp%0d.out_valid", c), 32'(out_valid), 32'd1);
            chk($sformatf("bp%0d.out_data", c),  32'(out_data),  32'hB1);
            chk($sformatf("bp%0d.out_ch", c),    32'(out_ch),    32'd1);
        end
        drive(2'b01, 2'd0, 3'b111, D0, 1'b1);
        #1;
        chk("bp_release.in_ready", 32'(in_ready), 32'b100);
        tick();
        chk("bp_release.out_valid", 32'(out_valid), 32'd1);
        chk("bp_release.out_data",  32'(out_data),  32'hC2);
        chk("bp_release.out_ch",    32'(out_ch),    32'd2);
        tick();
        chk("pre_rst.out_ch", 32'(out_ch), 32'd0);  // pointer now 1

        // Reset mid-stream with a beat held.
        out_ready = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst.out_valid", 32'(out_valid), 32'd0);
        chk("async_rst.out_data",  32'(out_data),  32'd0);
        chk("async_rst.in_ready",  32'(in_ready),  32'd0);
        tick();
        rst_n = 1'b1;
        drive(2'b01, 2'd0, 3'b111, D0, 1'b1);
        #1;
        chk("post_rst.in_ready", 32'(in_ready), 32'b001);
        tick();
        chk("post_rst.out_valid", 32'(out_valid), 32'd1);
        chk("post_rst.out_ch",    32'(out_ch),    32'd0);
        chk("post_rst.out_data",  32'(out_data),  32'hA0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stream_mux_rr.md
STREAM_MUX_RR -- requirements
Module: stream_mux_rr

Interface
REQ-001 The block SHALL take parameter NCH, default 3: number of input channels, 2..16.
REQ-002 The block SHALL take parameter W, default 8: data width per channel, 1..64.
REQ-003 The block SHALL use parameter SW = clog2(NCH), derived and not overridable: select and grant width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset; asynchronous, active-low.
REQ-006 in_valid  input  NCH  per-channel valid.
REQ-007 in_data  input  NCH*W  channel k occupies bits [k*W +: W].
REQ-008 in_ready  output  NCH  per-channel accept; one-hot or zero.
REQ-009 mode  input  2  00 fixed priority, 01 round-robin, 10 forced select, 11 treated as 01.
REQ-010 sel  input  SW  channel index used in forced-select mode.
REQ-011 out_valid  output  1  output register holds a beat.
REQ-012 out_data  output  W  registered beat data.
REQ-013 out_ready  input  1  downstream accept.
REQ-014 out_ch  output  SW  source channel of the current out_data.

Function
REQ-015 A transfer SHALL occur on an input when in_valid[k] and in_ready[k] are high at a clock edge; the output transfer occurs when out_valid and out_ready are both high.
REQ-016 Output stage free: out_valid==0, or out_ready==1.
REQ-017 When the output stage is free, in_ready SHALL be one-hot on the granted channel; otherwise in_ready SHALL be all zero. in_ready SHALL be combinational from the current state and inputs.
REQ-018 Fixed priority: grant SHALL go to the lowest-index channel with in_valid set.
REQ-019 Round-robin: search SHALL start at pointer rr_ptr and wrap modulo NCH; after each accepted input, rr_ptr becomes (grant+1) mod NCH.
REQ-020 Forced select: grant SHALL be sel only if in_valid[sel] is set; sel >= NCH maps to channel NCH-1.
REQ-021 On an input transfer, out_data, out_ch and out_valid=1 SHALL load at that edge: latency is 1 cycle.
REQ-022 If the output transfers and no input transfers at the same edge, out_valid SHALL clear. Simultaneous output and input transfer SHALL load the new beat with no bubble, giving full throughput.
REQ-023 While out_valid=1 and out_ready=0, out_data and out_ch SHALL hold stable.
REQ-024 rr_ptr SHALL change only on an accepted input. A mode change takes effect on the next grant.
REQ-025 When no in_valid bit is set, no grant SHALL be made and rr_ptr holds.

Reset
REQ-026 While rst_n=0: out_valid=0, out_data=0, out_ch=0, rr_ptr=0, in_ready=0.
REQ-027 Assertion of rst_n mid-transfer SHALL drop any held beat immediately; the first grant after release SHALL follow REQ-018..020 from rr_ptr=0.

Structure
REQ-028 Package stream_mux_pkg SHALL hold the mode encodings MODE_FIXED, MODE_RR, MODE_FORCE and MODE_RSVD.
REQ-029 Grant logic SHALL be a sub-module rr_arbiter with inputs req[NCH], ptr and mode, and output one-hot gnt plus gnt_idx. The top module holds the output register and rr_ptr.

Verification
REQ-030 Round-robin, all three channels valid, out_ready=1: out_ch sequence 0,1,2,0,1,2 on consecutive cycles, no bubbles.
REQ-031 Fixed priority, in_valid=3'b110: out_ch=1 every cycle and channel 2 is never granted; then in_valid=3'b100 gives out_ch=2.
REQ-032 Forced select, sel=3 (NCH=3), in_valid=3'b111, in_data ch2=8'hA5: out_data=8'hA5, out_ch=2.
REQ-033 Backpressure, out_ready=0 for 4 cycles with a beat held: in_ready=0 and out_data stable; on out_ready=1, the held beat completes and the next beat loads at the same edge.
REQ-034 Reset mid-stream: assert rst_n=0 while out_valid=1, then observe out_valid=0 asynchronously; after release in round-robin mode with all channels valid, the first out_ch=0.
REQ-035 Idle, in_valid=0: out_valid clears after draining and rr_ptr stays unchanged, so the next grant resumes at the pointer.
